// File: rtl/io_arb_pkg.sv
// Shared state encoding, address limit and counter width for the IO port arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] IO_ADDR_MAX = 8'h07;
    localparam int         CNT_W       = 4;

    function automatic logic addr_in_range(input logic [7:0] addr);
        return (addr <= IO_ADDR_MAX);
    endfunction

endpackage

// File: rtl/io_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant; purely combinational, zero latency.
// No backpressure: the one-hot grant is only meaningful while en_i is high.
module rr_arb2 (
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i = 1 means m1 won the previous arbitration, so m0 wins a tie.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
            else                gnt_o = req_i;
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Round-robin sequencer for two masters onto the 8-channel IO port; ack after S+1 cycles (1 if out of range).
// Masters hold req until their ack; a losing request simply waits, it is only sampled in IDLE.
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int STROBE_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    output logic       m0_err,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       m1_err,
    output logic [7:0] io_addr,
    output logic       io_re,
    output logic       io_we,
    output logic [7:0] io_din,
    input  logic [7:0] io_dout,
    output logic       busy
);

    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             gnt_m1_q;
    logic [7:0]       io_addr_q, io_din_q;
    logic             io_re_q, io_we_q;
    logic             m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
    logic [7:0]       m0_rdata_q, m1_rdata_q;
    logic             busy_q;

    logic [1:0]       gnt;
    logic             sel_we;
    logic [7:0]       sel_addr, sel_wdata;

    rr_arb2 u_rr_arb2 (
        .en_i   (state_q == IDLE),
        .req_i  ({m1_req, m0_req}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign sel_we    = gnt[1] ? m1_we    : m0_we;
    assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_m1_q   <= 1'b0;
            io_addr_q  <= 8'h00;
            io_din_q   <= 8'h00;
            io_re_q    <= 1'b0;
            io_we_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 8'h00;
            m1_rdata_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        last_q    <= gnt[1];
                        gnt_m1_q  <= gnt[1];
                        io_addr_q <= sel_addr;
                        io_din_q  <= sel_wdata;
                        busy_q    <= 1'b1;
                        if (addr_in_range(sel_addr)) begin
                            state_q <= STROBE;
                            io_re_q <= ~sel_we;
                            io_we_q <= sel_we;
                            cnt_q   <= STROBE_LD;
                        end else begin
                            // Out-of-range: skip the strobe and complete with an error.
                            state_q <= ACK;
                            if (gnt[1]) begin
                                m1_ack_q   <= 1'b1;
                                m1_err_q   <= 1'b1;
                                m1_rdata_q <= 8'h00;
                            end else begin
                                m0_ack_q   <= 1'b1;
                                m0_err_q   <= 1'b1;
                                m0_rdata_q <= 8'h00;
                            end
                        end
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        if (io_re_q) begin
                            if (gnt_m1_q) m1_rdata_q <= io_dout;
                            else          m0_rdata_q <= io_dout;
                        end
                        io_re_q  <= 1'b0;
                        io_we_q  <= 1'b0;
                        m0_ack_q <= ~gnt_m1_q;
                        m1_ack_q <= gnt_m1_q;
                        state_q  <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ACK: begin
                    if (RECOVERY_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RECOVER;
                        cnt_q   <= RECOV_LD;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_addr  = io_addr_q;
    assign io_din   = io_din_q;
    assign io_re    = io_re_q;
    assign io_we    = io_we_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: default instance (S=2, R=1) plus a fast instance (S=1, R=0).
// Acks are matched against a queue of expected completions pushed when each request is driven.
module tb_io_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m0_addr = 8'h00, m0_wdata = 8'h00, m1_addr = 8'h00, m1_wdata = 8'h00;
    logic       m0_ack, m0_err, m1_ack, m1_err, io_re, io_we, busy;
    logic [7:0] m0_rdata, m1_rdata, io_addr, io_din, io_dout;
    logic       dout_fn = 1'b0;
    logic [7:0] dout_r  = 8'h00;

    // The port model either returns a per-cycle constant or a value derived from the address.
    assign io_dout = dout_fn ? ~io_addr : dout_r;

    io_port_arbiter #(.STROBE_CYCLES(2), .RECOVERY_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .io_addr(io_addr), .io_re(io_re), .io_we(io_we), .io_din(io_din),
        .io_dout(io_dout), .busy(busy)
    );

    logic       b_m0_req = 1'b0;
    logic       b_m0_we = 1'b0, b_m1_req = 1'b0, b_m1_we = 1'b0;
    logic [7:0] b_m0_addr = 8'h03, b_m0_wdata = 8'h00, b_m1_addr = 8'h00, b_m1_wdata = 8'h00;
    logic [7:0] b_io_dout = 8'h77;
    logic       b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_io_re, b_io_we, b_busy;
    logic [7:0] b_m0_rdata, b_m1_rdata, b_io_addr, b_io_din;

    io_port_arbiter #(.STROBE_CYCLES(1), .RECOVERY_CYCLES(0)) u_dut_fast (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .io_addr(b_io_addr), .io_re(b_io_re), .io_we(b_io_we), .io_din(b_io_din),
        .io_dout(b_io_dout), .busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       m1;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mdl_rd [2];

    // Track each master's held read data so writes expect the previous value.
    task automatic push(input logic m1, input logic is_rd, input logic oor, input logic [7:0] rdv);
        exp_t e;
        if (oor)        mdl_rd[m1] = 8'h00;
        else if (is_rd) mdl_rd[m1] = rdv;
        e.m1    = m1;
        e.rdata = mdl_rd[m1];
        e.err   = oor;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : sb_monitor
        exp_t e;
        if (!rst && (m0_ack || m1_ack)) begin
            chk("ack_onehot", 32'(m0_ack & m1_ack), 0);
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_master", 32'(m1_ack), 32'(e.m1));
                chk("sb_rdata", 32'(m1_ack ? m1_rdata : m0_rdata), 32'(e.rdata));
                chk("sb_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
            end
        end
    end

    initial begin
        int nre, nwe, nack, nerr, t_prev;
        mdl_rd[0] = 8'h00;
        mdl_rd[1] = 8'h00;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_io", 32'({io_re, io_we, io_addr, io_din}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
        chk("rst_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
        rst = 1'b0;
        tick();

        // m0 write 0x03 <- 0xA5
        m0_we = 1'b1; m0_addr = 8'h03; m0_wdata = 8'hA5; m0_req = 1'b1;
        push(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("t1_c1_io", 32'({io_re, io_we, io_addr, io_din}), 32'({1'b0, 1'b1, 8'h03, 8'hA5}));
        chk("t1_c1_busy", 32'(busy), 1);
        tick();
        chk("t1_c2", 32'({io_re, io_we, m0_ack}), 32'b010);
        tick();
        chk("t1_c3_ack", 32'({io_re, io_we, m0_ack}), 32'b001);
        m0_req = 1'b0;
        tick();
        chk("t1_c4_recover", 32'({busy, m0_ack, io_addr}), 32'({1'b1, 1'b0, 8'h03}));
        tick();
        chk("t1_c5_idle", 32'(busy), 0);

        // m1 read 0x06, port data valid only in the last strobe cycle
        m1_we = 1'b0; m1_addr = 8'h06; m1_req = 1'b1; dout_r = 8'h11;
        push(1'b1, 1'b1, 1'b0, 8'h5C);
        nre = 0; nwe = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            dout_r = (c == 2) ? 8'h5C : ((c == 1) ? 8'h11 : 8'hEE);
            nre += int'(io_re);
            nwe += int'(io_we);
            if (c == 3) begin
                chk("t2_c3_ack", 32'({m1_ack, m0_ack}), 32'b10);
                m1_req = 1'b0;
            end
        end
        chk("t2_re_cycles", nre, 2);
        chk("t2_we_cycles", nwe, 0);
        chk("t2_idle", 32'(busy), 0);

        // Reset so the first tie goes to m0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_rd[0] = 8'h00;
        mdl_rd[1] = 8'h00;
        chk("rst2_rdata", 32'({m0_rdata, m1_rdata}), 0);

        // Both masters request continuously: m0, m1, m0, m1
        dout_fn = 1'b1;
        m0_we = 1'b0; m0_addr = 8'h01; m1_we = 1'b0; m1_addr = 8'h02;
        m0_req = 1'b1; m1_req = 1'b1;
        push(1'b0, 1'b1, 1'b0, 8'hFE);
        push(1'b1, 1'b1, 1'b0, 8'hFD);
        push(1'b0, 1'b1, 1'b0, 8'hFE);
        push(1'b1, 1'b1, 1'b0, 8'hFD);
        nack = 0; t_prev = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            tick();
            if (m0_ack || m1_ack) begin
                chk("t3_ack_gap", c - t_prev, (nack == 0) ? 3 : 5);
                t_prev = c;
                nack++;
                if (nack == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        chk("t3_ack_count", nack, 4);
        repeat (2) tick();

        // m0 out-of-range read
        m0_addr = 8'h20; m0_we = 1'b0; m0_req = 1'b1;
        push(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("t4_c1", 32'({m0_ack, m0_err, io_re, io_we}), 32'b1100);
        chk("t4_m1_rdata", 32'(m1_rdata), 32'h0000_00FD);
        m0_req = 1'b0;
        nre = 0;
        repeat (2) begin
            tick();
            nre += int'(io_re) + int'(io_we);
        end
        chk("t4_no_strobe", nre, 0);

        // Reset in the second strobe cycle kills the transaction
        m0_addr = 8'h04; m0_req = 1'b1;
        tick();
        chk("t5_c1_re", 32'(io_re), 1);
        tick();
        rst = 1'b1;
        m0_req = 1'b0;
        tick();
        chk("t5_cut", 32'({io_re, busy, m0_ack}), 0);
        rst = 1'b0;
        mdl_rd[0] = 8'h00;
        mdl_rd[1] = 8'h00;
        nack = 0;
        repeat (6) begin
            tick();
            nack += int'(m0_ack) + int'(m1_ack);
        end
        chk("t5_no_ack", nack, 0);
        m1_addr = 8'h05; m1_we = 1'b0; m1_req = 1'b1;
        push(1'b1, 1'b1, 1'b0, 8'hFA);
        nack = 0;
        for (int c = 1; c <= 10 && nack == 0; c++) begin
            tick();
            if (m1_ack) begin
                nack = 1;
                chk("t5_m1_latency", c, 3);
                m1_req = 1'b0;
            end
        end
        chk("t5_m1_done", nack, 1);
        repeat (2) tick();

        // Fast instance: S=1, R=0, m0 request held high
        b_m0_req = 1'b1;
        nre = 0; nack = 0; nerr = 0; t_prev = 0;
        for (int c = 1; c <= 29; c++) begin
            tick();
            nre  += int'(b_io_re);
            nerr += int'(b_m0_err);
            if (b_m0_ack) begin
                chk("t6_ack_gap", c - t_prev, (nack == 0) ? 2 : 3);
                t_prev = c;
                nack++;
            end
            if (c == 29) b_m0_req = 1'b0;
        end
        chk("t6_re_count", nre, 10);
        chk("t6_ack_count", nack, 10);
        chk("t6_err", nerr, 0);
        chk("t6_rdata", 32'(b_m0_rdata), 32'h0000_0077);
        chk("t6_io", 32'({b_io_addr, b_io_din}), 32'h0000_0300);
        repeat (2) tick();
        chk("t6_idle", 32'({b_busy, b_io_we, b_m1_ack, b_m1_err, b_m1_rdata}), 0);

        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
